// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared encodings and types for the pipeline hazard controller.
package pipeline_hazard_ctrl_pkg;

  localparam int unsigned REG_W  = 5;
  localparam int unsigned ADDR_W = 32;

  // Decode-stage forward selects (branch compare operands)
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_E  = 2'b10;
  localparam logic [1:0] FWD_M  = 2'b01;
  localparam logic [1:0] FWD_W  = 2'b11;

  // Execute-stage forward selects
  localparam logic [1:0] FWDE_REG = 2'b00;
  localparam logic [1:0] FWDE_M   = 2'b10;
  localparam logic [1:0] FWDE_W   = 2'b01;

  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_RUN  = 2'd1;
  localparam logic [1:0] DIV_DONE = 2'd2;

  localparam logic [0:0] EXC_IDLE = 1'b0;
  localparam logic [0:0] EXC_PEND = 1'b1;

  localparam logic [ADDR_W-1:0] EXC_VECTOR_DEFAULT = 32'hbfc00380;

  typedef struct packed {
    logic f;
    logic d;
    logic e;
    logic m;
    logic w;
  } stage_ctl_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_select.sv
// Forward source select for one operand; DECODE picks the decode-stage code set.
module fwd_select
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter bit DECODE = 1'b0
) (
  input  logic [REG_W-1:0] src_i,
  input  logic [REG_W-1:0] writereg_e_i,
  input  logic [REG_W-1:0] writereg_m_i,
  input  logic [REG_W-1:0] writereg_w_i,
  input  logic             regwrite_e_i,
  input  logic             regwrite_m_i,
  input  logic             regwrite_w_i,
  input  logic             memtoreg_e_i,
  output logic [1:0]       sel_o
);

  // Youngest producer wins; a load in E has no data yet so it is never a source
  always_comb begin
    sel_o = DECODE ? FWD_RF : FWDE_REG;
    if (src_i != '0) begin
      if (DECODE && regwrite_e_i && !memtoreg_e_i && (src_i == writereg_e_i)) begin
        sel_o = FWD_E;
      end else if (regwrite_m_i && (src_i == writereg_m_i)) begin
        sel_o = DECODE ? FWD_M : FWDE_M;
      end else if (regwrite_w_i && (src_i == writereg_w_i)) begin
        sel_o = DECODE ? FWD_W : FWDE_W;
      end
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for a 5-stage MIPS pipeline: forwarding,
// stall/flush priority, divider sequencing and exception redirect ordering.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned       DIV_CYCLES = 36,
  parameter logic [ADDR_W-1:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [REG_W-1:0]  rsD,
  input  logic [REG_W-1:0]  rtD,
  input  logic [REG_W-1:0]  rsE,
  input  logic [REG_W-1:0]  rtE,
  input  logic [REG_W-1:0]  writeregE,
  input  logic [REG_W-1:0]  writeregM,
  input  logic [REG_W-1:0]  writeregW,
  input  logic              regwriteE,
  input  logic              regwriteM,
  input  logic              regwriteW,
  input  logic              memtoregE,
  input  logic              memtoregM,
  input  logic              branchD,
  input  logic              divE,
  input  logic              inst_busy,
  input  logic              data_busy,
  input  logic              exceptM,
  input  logic              eretM,
  input  logic [ADDR_W-1:0] epc,
  output logic [1:0]        forwardaD,
  output logic [1:0]        forwardbD,
  output logic [1:0]        forwardaE,
  output logic [1:0]        forwardbE,
  output logic              stallF,
  output logic              stallD,
  output logic              stallE,
  output logic              stallM,
  output logic              stallW,
  output logic              flushD,
  output logic              flushE,
  output logic              flushM,
  output logic              flushW,
  output logic              div_start,
  output logic              div_abort,
  output logic              div_done,
  output logic              redirect,
  output logic [ADDR_W-1:0] redirect_pc
);

  localparam int unsigned CNT_W = $clog2(DIV_CYCLES);

  logic [1:0]        div_st_q, div_st_d;
  logic [0:0]        exc_st_q, exc_st_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;

  logic [1:0]        fwd_ad, fwd_bd, fwd_ae, fwd_be;
  stage_ctl_t        stall;
  logic              fl_d, fl_e, fl_m, fl_w;
  logic              start_s, abort_s, done_s, redir_s;
  logic [ADDR_W-1:0] rpc_s;
  logic              exc_now, bus_wait, load_use, br_haz;
  logic [ADDR_W-1:0] exc_tgt;

  fwd_select #(.DECODE(1'b1)) u_fwd_ad (
    .src_i(rsD), .writereg_e_i(writeregE), .writereg_m_i(writeregM), .writereg_w_i(writeregW),
    .regwrite_e_i(regwriteE), .regwrite_m_i(regwriteM), .regwrite_w_i(regwriteW),
    .memtoreg_e_i(memtoregE), .sel_o(fwd_ad));
  fwd_select #(.DECODE(1'b1)) u_fwd_bd (
    .src_i(rtD), .writereg_e_i(writeregE), .writereg_m_i(writeregM), .writereg_w_i(writeregW),
    .regwrite_e_i(regwriteE), .regwrite_m_i(regwriteM), .regwrite_w_i(regwriteW),
    .memtoreg_e_i(memtoregE), .sel_o(fwd_bd));
  fwd_select #(.DECODE(1'b0)) u_fwd_ae (
    .src_i(rsE), .writereg_e_i(writeregE), .writereg_m_i(writeregM), .writereg_w_i(writeregW),
    .regwrite_e_i(regwriteE), .regwrite_m_i(regwriteM), .regwrite_w_i(regwriteW),
    .memtoreg_e_i(memtoregE), .sel_o(fwd_ae));
  fwd_select #(.DECODE(1'b0)) u_fwd_be (
    .src_i(rtE), .writereg_e_i(writeregE), .writereg_m_i(writeregM), .writereg_w_i(writeregW),
    .regwrite_e_i(regwriteE), .regwrite_m_i(regwriteM), .regwrite_w_i(regwriteW),
    .memtoreg_e_i(memtoregE), .sel_o(fwd_be));

  assign exc_now  = (exc_st_q == EXC_IDLE) && (exceptM || eretM);
  assign exc_tgt  = exceptM ? EXC_VECTOR : epc;
  assign bus_wait = inst_busy || data_busy;
  assign load_use = memtoregE && regwriteE && ((rsD == writeregE) || (rtD == writeregE));
  assign br_haz   = branchD && memtoregM && ((rsD == writeregM) || (rtD == writeregM));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_st_q <= DIV_IDLE;
      exc_st_q <= EXC_IDLE;
      cnt_q    <= '0;
      tgt_q    <= '0;
    end else begin
      div_st_q <= div_st_d;
      exc_st_q <= exc_st_d;
      cnt_q    <= cnt_d;
      tgt_q    <= tgt_d;
    end
  end

  // Next state and stall/flush priority: exception > bus wait > divider > load-use/branch
  always_comb begin
    div_st_d = div_st_q;
    exc_st_d = exc_st_q;
    cnt_d    = cnt_q;
    tgt_d    = tgt_q;
    stall    = '0;
    fl_d     = 1'b0;
    fl_e     = 1'b0;
    fl_m     = 1'b0;
    fl_w     = 1'b0;
    start_s  = 1'b0;
    abort_s  = 1'b0;
    done_s   = 1'b0;
    redir_s  = 1'b0;
    rpc_s    = '0;

    if (exc_now) begin
      {fl_d, fl_e, fl_m, fl_w} = 4'b1111;
      rpc_s   = exc_tgt;
      stall.f = inst_busy;
      redir_s = !inst_busy;
      if (inst_busy) begin
        exc_st_d = EXC_PEND;
        tgt_d    = exc_tgt;
      end
      if (div_st_q != DIV_IDLE) begin
        abort_s  = 1'b1;
        div_st_d = DIV_IDLE;
        cnt_d    = '0;
      end
    end else begin
      if (exc_st_q == EXC_PEND) begin
        rpc_s = tgt_q;
        if (!inst_busy) begin
          redir_s  = 1'b1;
          exc_st_d = EXC_IDLE;
        end
      end

      if (bus_wait) begin
        stall = '1;
      end else if (div_st_q == DIV_RUN) begin
        stall.f = 1'b1;
        stall.d = 1'b1;
        stall.e = 1'b1;
        fl_m    = 1'b1;
      end else if (load_use || br_haz) begin
        stall.f = 1'b1;
        stall.d = 1'b1;
        fl_e    = 1'b1;
      end

      case (div_st_q)
        DIV_IDLE: begin
          if (divE && !bus_wait) begin
            start_s  = 1'b1;
            div_st_d = DIV_RUN;
            cnt_d    = CNT_W'(DIV_CYCLES - 1);
          end
        end
        DIV_RUN: begin
          if (cnt_q == '0) div_st_d = DIV_DONE;
          else             cnt_d    = cnt_q - CNT_W'(1);
        end
        DIV_DONE: begin
          done_s   = 1'b1;
          div_st_d = DIV_IDLE;
        end
        default: div_st_d = DIV_IDLE;
      endcase
    end
  end

  // Everything is forced low while reset is held
  assign forwardaD   = {2{resetn}} & fwd_ad;
  assign forwardbD   = {2{resetn}} & fwd_bd;
  assign forwardaE   = {2{resetn}} & fwd_ae;
  assign forwardbE   = {2{resetn}} & fwd_be;
  assign stallF      = resetn & stall.f;
  assign stallD      = resetn & stall.d;
  assign stallE      = resetn & stall.e;
  assign stallM      = resetn & stall.m;
  assign stallW      = resetn & stall.w;
  assign flushD      = resetn & fl_d;
  assign flushE      = resetn & fl_e;
  assign flushM      = resetn & fl_m;
  assign flushW      = resetn & fl_w;
  assign div_start   = resetn & start_s;
  assign div_abort   = resetn & abort_s;
  assign div_done    = resetn & done_s;
  assign redirect    = resetn & redir_s;
  assign redirect_pc = {ADDR_W{resetn}} & rpc_s;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic [4:0]  rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic        regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
  logic        branchD, divE, inst_busy, data_busy, exceptM, eretM;
  logic [31:0] epc;
  logic [1:0]  forwardaD, forwardbD, forwardaE, forwardbE;
  logic        stallF, stallD, stallE, stallM, stallW;
  logic        flushD, flushE, flushM, flushW;
  logic        div_start, div_abort, div_done, redirect;
  logic [31:0] redirect_pc;

  logic [4:0]  stv;
  logic [3:0]  flv;
  int          checks = 0;
  int          passes = 0;
  int          fails  = 0;
  int          run_ok;
  logic        seen;

  assign stv = {stallF, stallD, stallE, stallM, stallW};
  assign flv = {flushD, flushE, flushM, flushW};

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.DIV_CYCLES(36), .EXC_VECTOR(32'hbfc00380)) dut (
    .clk(clk), .resetn(resetn),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
    .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .memtoregE(memtoregE), .memtoregM(memtoregM),
    .branchD(branchD), .divE(divE), .inst_busy(inst_busy), .data_busy(data_busy),
    .exceptM(exceptM), .eretM(eretM), .epc(epc),
    .forwardaD(forwardaD), .forwardbD(forwardbD), .forwardaE(forwardaE), .forwardbE(forwardbE),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM), .stallW(stallW),
    .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
    .div_start(div_start), .div_abort(div_abort), .div_done(div_done),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_in();
    rsD = '0; rtD = '0; rsE = '0; rtE = '0;
    writeregE = '0; writeregM = '0; writeregW = '0;
    regwriteE = 1'b0; regwriteM = 1'b0; regwriteW = 1'b0;
    memtoregE = 1'b0; memtoregM = 1'b0; branchD = 1'b0; divE = 1'b0;
    inst_busy = 1'b0; data_busy = 1'b0; exceptM = 1'b0; eretM = 1'b0;
    epc = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset holds every output low even with active-looking inputs
    clr_in();
    resetn = 1'b0;
    rsD = 5'd5; writeregE = 5'd5; regwriteE = 1'b1; divE = 1'b1; exceptM = 1'b1; epc = 32'h1234;
    #2;
    chk("rst_fwdaD", 32'(forwardaD), 32'h0);
    chk("rst_stall", 32'(stv), 32'h0);
    chk("rst_flush", 32'(flv), 32'h0);
    chk("rst_redirect", 32'(redirect), 32'h0);
    chk("rst_redirect_pc", redirect_pc, 32'h0);
    chk("rst_div_start", 32'(div_start), 32'h0);
    clr_in();
    @(negedge clk);
    resetn = 1'b1;

    // Forwarding
    writeregE = 5'd5; regwriteE = 1'b1; rsD = 5'd5; #1;
    chk("fwdaD_E", 32'(forwardaD), 32'b10);
    chk("fwd_nostall", 32'(stv), 32'h0);
    rsD = 5'd0; #1;
    chk("fwdaD_r0", 32'(forwardaD), 32'b00);
    clr_in();
    rtD = 5'd7; writeregM = 5'd7; regwriteM = 1'b1; writeregW = 5'd7; regwriteW = 1'b1; #1;
    chk("fwdbD_M_over_W", 32'(forwardbD), 32'b01);
    regwriteM = 1'b0; #1;
    chk("fwdbD_W", 32'(forwardbD), 32'b11);
    clr_in();
    rsE = 5'd7; rtE = 5'd9; writeregM = 5'd7; regwriteM = 1'b1; writeregW = 5'd9; regwriteW = 1'b1; #1;
    chk("fwdaE_M", 32'(forwardaE), 32'b10);
    chk("fwdbE_W", 32'(forwardbE), 32'b01);

    // Load in E: no E forward, load-use stall; bus wait overrides it
    clr_in();
    rsD = 5'd5; writeregE = 5'd5; regwriteE = 1'b1; memtoregE = 1'b1;
    writeregW = 5'd5; regwriteW = 1'b1; #1;
    chk("lu_fwdaD_skipE", 32'(forwardaD), 32'b11);
    chk("lu_stall", 32'(stv), 32'b11000);
    chk("lu_flush", 32'(flv), 32'b0100);
    data_busy = 1'b1; #1;
    chk("bus_stall", 32'(stv), 32'b11111);
    chk("bus_noflush", 32'(flv), 32'b0000);

    // Load followed by branch: load-use, then branch hazard with M forward, then W forward
    clr_in();
    branchD = 1'b1; rsD = 5'd5; writeregE = 5'd5; regwriteE = 1'b1; memtoregE = 1'b1; #1;
    chk("lwbr_stall", 32'(stv), 32'b11000);
    chk("lwbr_flush", 32'(flv), 32'b0100);
    writeregE = '0; regwriteE = 1'b0; memtoregE = 1'b0;
    writeregM = 5'd5; regwriteM = 1'b1; memtoregM = 1'b1; #1;
    chk("lwbr_fwdaD_M", 32'(forwardaD), 32'b01);
    chk("lwbr_br_stall", 32'(stv), 32'b11000);
    writeregM = '0; regwriteM = 1'b0; memtoregM = 1'b0;
    writeregW = 5'd5; regwriteW = 1'b1; #1;
    chk("lwbr_fwdaD_W", 32'(forwardaD), 32'b11);
    chk("lwbr_nostall", 32'(stv), 32'h0);

    // Divide: start pulse, 36 stall cycles, done on cycle 37
    clr_in();
    cyc();
    divE = 1'b1; #1;
    chk("div_start", 32'(div_start), 32'h1);
    chk("div_start_nostall", 32'(stv), 32'h0);
    cyc();
    divE = 1'b0;
    run_ok = 0;
    for (int i = 0; i < 36; i++) begin
      if (stv == 5'b11100 && flv == 4'b0010 && !div_done && !div_start) run_ok++;
      cyc();
    end
    chk("div_run_cycles", 32'(run_ok), 32'd36);
    chk("div_done_c37", 32'(div_done), 32'h1);
    chk("div_done_nostall", 32'(stv), 32'h0);
    cyc();
    chk("div_done_once", 32'(div_done), 32'h0);

    // Exception with fetch outstanding for 3 cycles
    exceptM = 1'b1; inst_busy = 1'b1; #1;
    chk("exc_flush", 32'(flv), 32'b1111);
    chk("exc_no_redirect", 32'(redirect), 32'h0);
    chk("exc_stallF", 32'(stallF), 32'h1);
    cyc();
    exceptM = 1'b0; #1;
    chk("pend1_redirect", 32'(redirect), 32'h0);
    chk("pend1_stallF", 32'(stallF), 32'h1);
    cyc();
    chk("pend2_redirect", 32'(redirect), 32'h0);
    cyc();
    inst_busy = 1'b0; #1;
    chk("pend3_redirect", 32'(redirect), 32'h1);
    chk("pend3_pc", redirect_pc, 32'hbfc00380);
    cyc();
    chk("pend_done", 32'(redirect), 32'h0);

    // ERET redirects to EPC; exception wins when both are raised
    eretM = 1'b1; epc = 32'h8000_1234; #1;
    chk("eret_redirect", 32'(redirect), 32'h1);
    chk("eret_pc", redirect_pc, 32'h8000_1234);
    chk("eret_flush", 32'(flv), 32'b1111);
    exceptM = 1'b1; #1;
    chk("exc_eret_pc", redirect_pc, 32'hbfc00380);
    clr_in();
    cyc();

    // Exception at RUN cycle 10 aborts the divide
    divE = 1'b1; #1;
    cyc();
    divE = 1'b0;
    repeat (9) cyc();
    chk("run10_stallE", 32'(stallE), 32'h1);
    exceptM = 1'b1; #1;
    chk("abort_pulse", 32'(div_abort), 32'h1);
    chk("abort_flush", 32'(flv), 32'b1111);
    chk("abort_stallE", 32'(stallE), 32'h0);
    cyc();
    exceptM = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      if (div_done || div_start || div_abort || stallE) seen = 1'b1;
      cyc();
    end
    chk("abort_no_done", 32'(seen), 32'h0);

    // Reset mid-RUN
    divE = 1'b1; #1;
    cyc();
    divE = 1'b0;
    repeat (3) cyc();
    chk("rstrun_pre", 32'(stallE), 32'h1);
    #2 resetn = 1'b0;
    #1;
    chk("rstrun_stall", 32'(stv), 32'h0);
    chk("rstrun_flush", 32'(flv), 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    seen = 1'b0;
    repeat (45) begin
      if (div_done || stallE || redirect || div_abort) seen = 1'b1;
      cyc();
    end
    chk("rstrun_quiet", 32'(seen), 32'h0);

    // Reset mid-PEND
    exceptM = 1'b1; inst_busy = 1'b1; #1;
    cyc();
    exceptM = 1'b0; #1;
    chk("rstpend_pre", 32'(stallF), 32'h1);
    #1 resetn = 1'b0;
    #1;
    chk("rstpend_stallF", 32'(stallF), 32'h0);
    chk("rstpend_pc", redirect_pc, 32'h0);
    inst_busy = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      if (redirect) seen = 1'b1;
      cyc();
    end
    chk("rstpend_no_redirect", 32'(seen), 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
